// File: rtl/rec_pkg.sv
// Shared types and constants for the audio recorder sequencer and its display block.
package rec_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        REC   = 3'd2,
        PLAY  = 3'd3,
        PAUSE = 3'd4
    } state_t;

    localparam int         ADDR_W_DEFAULT = 20;
    localparam logic [3:0] SPEED_MIN      = 4'd1;
    localparam logic [3:0] SPEED_MAX      = 4'd8;

endpackage

// File: rtl/speed_decode.sv
// Priority encoder from the speed-select switches to a playback speed factor.
module speed_decode
    import rec_pkg::*;
(
    input  logic [6:0] i_sel,
    output logic [3:0] o_speed
);

    // Bit k of i_sel is switch k+2; the highest set switch wins.
    always_comb begin
        // NOTE: default first so every path assigns o_speed and no latch is inferred.
        o_speed = SPEED_MIN;
        for (int k = 0; k < 7; k++) begin
            if (i_sel[k]) o_speed = 4'(k + 2);
        end
    end

endmodule

// File: rtl/rec_play_ctrl.sv
// Record/play/pause sequencer: owns the SRAM address counter, the write strobe
// and the variable-speed playback stepping.
module rec_play_ctrl
    import rec_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_key_rec,
    input  logic              i_key_play,
    input  logic              i_key_stop,
    input  logic [17:0]       i_sw,
    input  logic              i_adc_valid,
    input  logic              i_dac_req,
    output logic [2:0]        o_state,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_we,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic [3:0]        o_speed,
    output logic              o_fast
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              full_q, full_d;
    logic [2:0]        sub_q, sub_d;
    logic [3:0]        speed_q, speed_dec;
    logic              fast_q;

    logic              key_stop, key_rec, key_play;
    logic [ADDR_W:0]   len, wr_count, step_next;
    logic              sub_wrap, step_done;
    logic [2:0]        step_sub;
    logic              unused_sw;

    speed_decode u_speed_decode (
        .i_sel   (i_sw[8:2]),
        .o_speed (speed_dec)
    );

    assign unused_sw = ^{i_sw[16:9], i_sw[1:0]};

    assign key_stop = i_key_stop;
    assign key_rec  = i_key_rec & ~i_key_stop;
    assign key_play = i_key_play & ~i_key_rec & ~i_key_stop;

    // Stored length carries the full flag as its top bit, so a full memory never reads as empty.
    assign len      = {full_q, end_q};
    assign wr_count = {1'b0, addr_q} + {{ADDR_W{1'b0}}, i_adc_valid};

    assign sub_wrap = ({1'b0, sub_q} >= (speed_q - 4'd1));
    always_comb begin
        step_next = {1'b0, addr_q} + {{ADDR_W{1'b0}}, sub_wrap};
        step_sub  = sub_wrap ? 3'd0 : sub_q + 3'd1;
        if (fast_q) begin
            step_next = {1'b0, addr_q} + {{(ADDR_W-3){1'b0}}, speed_q};
            step_sub  = 3'd0;
        end
    end
    assign step_done = (step_next >= len);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        end_d   = end_q;
        full_d  = full_q;
        sub_d   = sub_q;

        unique case (state_q)
            IDLE: ;
            REC: begin
                if (i_adc_valid) addr_d = addr_q + 1'b1;
                if (key_stop || (i_adc_valid && addr_q == MAX_ADDR)) begin
                    state_d = HOLD;
                    addr_d  = '0;
                    end_d   = wr_count[ADDR_W-1:0];
                    full_d  = wr_count[ADDR_W];
                end
            end
            HOLD: begin
                if (key_play && len != '0) begin
                    state_d = PLAY;
                    addr_d  = '0;
                    sub_d   = 3'd0;
                end
            end
            PLAY: begin
                if (i_dac_req) begin
                    if (step_done) begin
                        state_d = HOLD;
                        addr_d  = '0;
                        sub_d   = 3'd0;
                    end else begin
                        addr_d  = step_next[ADDR_W-1:0];
                        sub_d   = step_sub;
                    end
                end
                if (key_play) state_d = PAUSE;
            end
            PAUSE: begin
                if (key_play) state_d = PLAY;
            end
            default: state_d = IDLE;
        endcase

        // Stop and rec leave the playback states the same way.
        if ((state_q == PLAY || state_q == PAUSE) && key_stop) begin
            state_d = HOLD;
            addr_d  = '0;
            sub_d   = 3'd0;
        end
        if (state_q != REC && key_rec) begin
            state_d = REC;
            addr_d  = '0;
            end_d   = '0;
            full_d  = 1'b0;
            sub_d   = 3'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            full_q  <= 1'b0;
            sub_q   <= 3'd0;
            speed_q <= SPEED_MIN;
            fast_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            full_q  <= full_d;
            sub_q   <= sub_d;
            speed_q <= speed_dec;
            fast_q  <= i_sw[17];
        end
    end

    assign o_state     = state_q;
    assign o_sram_addr = addr_q;
    assign o_sram_we   = (state_q == REC) && i_adc_valid;
    assign o_end_addr  = end_q;
    assign o_speed     = speed_q;
    assign o_fast      = fast_q;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Scoreboard bench for rec_play_ctrl: expected writes and state snapshots are queued by
// the stimulus and popped by a monitor on the falling edge.
module tb_rec_play_ctrl;
    import rec_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_s, key_rec, key_play, key_stop, adc, dac;
    logic [17:0] sw;

    logic [2:0]  m_state, s_state;
    logic [19:0] m_addr, s_addr, m_end, s_end;
    logic        m_we, s_we, m_fast, s_fast;
    logic [3:0]  m_speed, s_speed;

    rec_play_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_key_rec(key_rec), .i_key_play(key_play),
        .i_key_stop(key_stop), .i_sw(sw), .i_adc_valid(adc), .i_dac_req(dac),
        .o_state(m_state), .o_sram_addr(m_addr), .o_sram_we(m_we),
        .o_end_addr(m_end), .o_speed(m_speed), .o_fast(m_fast)
    );

    rec_play_ctrl #(.ADDR_W(20), .MAX_ADDR(20'd3)) dut_small (
        .i_clk(clk), .i_rst(rst_s), .i_key_rec(key_rec), .i_key_play(key_play),
        .i_key_stop(key_stop), .i_sw(sw), .i_adc_valid(adc), .i_dac_req(dac),
        .o_state(s_state), .o_sram_addr(s_addr), .o_sram_we(s_we),
        .o_end_addr(s_end), .o_speed(s_speed), .o_fast(s_fast)
    );

    typedef struct {
        string       name;
        bit          sel;
        logic [2:0]  st;
        logic [19:0] addr;
        logic [19:0] end_a;
        logic [3:0]  spd;
        logic        fast;
    } snap_t;

    snap_t       snap_q[$];
    logic [19:0] wq_m[$], wq_s[$];
    logic        snap_req = 1'b0;
    int          vectors = 0, miscompares = 0;

    snap_t       e_snap;
    logic [19:0] e_addr;
    logic [48:0] act, exp_v;

    always @(negedge clk) begin
        if (m_we) begin
            vectors++;
            if (wq_m.size() == 0) begin
                miscompares++;
                $display("FAIL main_write: unexpected we at addr %0d", m_addr);
            end else begin
                e_addr = wq_m.pop_front();
                if (m_addr !== e_addr) begin
                    miscompares++;
                    $display("FAIL main_write: addr got %0d expected %0d", m_addr, e_addr);
                end
            end
        end
        if (s_we) begin
            vectors++;
            if (wq_s.size() == 0) begin
                miscompares++;
                $display("FAIL small_write: unexpected we at addr %0d", s_addr);
            end else begin
                e_addr = wq_s.pop_front();
                if (s_addr !== e_addr) begin
                    miscompares++;
                    $display("FAIL small_write: addr got %0d expected %0d", s_addr, e_addr);
                end
            end
        end
        if (snap_req) begin
            vectors++;
            if (snap_q.size() == 0) begin
                miscompares++;
                $display("FAIL snapshot: no expected entry queued");
            end else begin
                e_snap = snap_q.pop_front();
                act = e_snap.sel ? {s_state, s_addr, s_end, s_speed, s_fast}
                                 : {m_state, m_addr, m_end, m_speed, m_fast};
                exp_v = {e_snap.st, e_snap.addr, e_snap.end_a, e_snap.spd, e_snap.fast};
                if (act !== exp_v) begin
                    miscompares++;
                    $display("FAIL %s: got state=%0d addr=%0d end=%0d speed=%0d fast=%0b expected state=%0d addr=%0d end=%0d speed=%0d fast=%0b",
                             e_snap.name, act[48:46], act[45:26], act[25:6], act[4:1], act[0],
                             exp_v[48:46], exp_v[45:26], exp_v[25:6], exp_v[4:1], exp_v[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        key_rec = 0; key_play = 0; key_stop = 0; adc = 0; dac = 0; snap_req = 0;
    endtask

    task automatic snap(input string n, input bit sel, input logic [2:0] st,
                        input logic [19:0] a, input logic [19:0] e,
                        input logic [3:0] spd, input logic f);
        snap_t s;
        s.name = n; s.sel = sel; s.st = st; s.addr = a; s.end_a = e; s.spd = spd; s.fast = f;
        snap_q.push_back(s);
        snap_req = 1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; rst_s = 1; sw = '0;
        key_rec = 0; key_play = 0; key_stop = 0; adc = 0; dac = 0;
        tick(); tick();
        rst = 0;
        snap("reset_main", 0, 3'd0, 0, 0, 4'd1, 0);

        // Record five samples, then stop.
        key_rec = 1; tick();
        snap("rec_start", 0, 3'd2, 0, 0, 4'd1, 0);
        for (int i = 0; i < 5; i++) begin
            wq_m.push_back(20'(i)); adc = 1; tick();
        end
        key_stop = 1; tick();
        snap("rec_stop_hold", 0, 3'd1, 0, 5, 4'd1, 0);

        // Fast playback at speed 3.
        sw[17] = 1; sw[3] = 1; tick();
        snap("speed_fast3", 0, 3'd1, 0, 5, 4'd3, 1);
        key_play = 1; tick();
        snap("play_start", 0, 3'd3, 0, 5, 4'd3, 1);
        dac = 1; tick();
        snap("fast_step", 0, 3'd3, 3, 5, 4'd3, 1);
        dac = 1; tick();
        snap("fast_end_hold", 0, 3'd1, 0, 5, 4'd3, 1);

        // Slow playback at speed 2: each address is held for two requests.
        sw = '0; sw[2] = 1; tick();
        snap("speed_slow2", 0, 3'd1, 0, 5, 4'd2, 0);
        key_play = 1; tick();
        dac = 1; tick(); snap("slow_req1", 0, 3'd3, 0, 5, 4'd2, 0);
        dac = 1; tick(); snap("slow_req2", 0, 3'd3, 1, 5, 4'd2, 0);
        dac = 1; tick(); snap("slow_req3", 0, 3'd3, 1, 5, 4'd2, 0);
        dac = 1; tick(); snap("slow_req4", 0, 3'd3, 2, 5, 4'd2, 0);

        // Pause freezes the address; resume steps from it.
        key_play = 1; tick();
        snap("pause_enter", 0, 3'd4, 2, 5, 4'd2, 0);
        for (int i = 0; i < 3; i++) begin
            dac = 1; tick();
        end
        snap("pause_ignores_dac", 0, 3'd4, 2, 5, 4'd2, 0);
        sw[17] = 1; tick();
        key_play = 1; tick();
        snap("resume", 0, 3'd3, 2, 5, 4'd2, 1);
        dac = 1; tick();
        snap("resume_step", 0, 3'd3, 4, 5, 4'd2, 1);

        // All three keys together: stop wins.
        key_stop = 1; key_rec = 1; key_play = 1; tick();
        snap("stop_priority", 0, 3'd1, 0, 5, 4'd2, 1);

        // Stop coinciding with the write at address 7 counts that write.
        key_rec = 1; tick();
        for (int i = 0; i < 7; i++) begin
            wq_m.push_back(20'(i)); adc = 1; tick();
        end
        wq_m.push_back(20'd7); adc = 1; key_stop = 1; tick();
        snap("stop_with_write", 0, 3'd1, 0, 8, 4'd2, 1);

        // Empty recording: play is ignored in HOLD.
        key_rec = 1; tick();
        key_stop = 1; tick();
        key_play = 1; tick();
        snap("empty_play_ignored", 0, 3'd1, 0, 0, 4'd2, 1);

        // Small memory (last address 3): auto-stop after four writes.
        sw = '0; tick();
        rst = 1; tick();
        rst = 0; rst_s = 0;
        snap("reset_small", 1, 3'd0, 0, 0, 4'd1, 0);
        snap("reset_main2", 0, 3'd0, 0, 0, 4'd1, 0);
        key_rec = 1; tick();
        for (int i = 0; i < 5; i++) begin
            wq_m.push_back(20'(i));
            if (i < 4) wq_s.push_back(20'(i));
            adc = 1; tick();
        end
        snap("small_full_hold", 1, 3'd1, 0, 4, 4'd1, 0);
        snap("main_still_rec", 0, 3'd2, 5, 0, 4'd1, 0);

        // Reset in the middle of a recording discards it.
        key_rec = 1; tick();
        wq_m.push_back(20'd5); wq_s.push_back(20'd0); adc = 1; tick();
        wq_m.push_back(20'd6); wq_s.push_back(20'd1); adc = 1; tick();
        rst = 1; rst_s = 1; tick();
        rst = 0; rst_s = 0;
        snap("mid_rec_reset_small", 1, 3'd0, 0, 0, 4'd1, 0);
        snap("mid_rec_reset_main", 0, 3'd0, 0, 0, 4'd1, 0);
        key_play = 1; tick();
        snap("play_after_reset_small", 1, 3'd0, 0, 0, 4'd1, 0);
        snap("play_after_reset_main", 0, 3'd0, 0, 0, 4'd1, 0);

        tick();
        vectors++;
        if (wq_m.size() != 0 || wq_s.size() != 0 || snap_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: pending main_writes=%0d small_writes=%0d snapshots=%0d expected 0",
                     wq_m.size(), wq_s.size(), snap_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rec_play_ctrl.md
Name: rec_play_ctrl

Overview:
- Top-level sequencer for the audio recorder: owns the record/play/pause state machine, the SRAM sample address counter, the write strobe and the variable-speed playback stepping.
- Sits between the key debouncers, the codec sample strobes and the SRAM port.
- Feeds o_state, o_sram_addr and switches to the seven-segment display block, which converts the address to elapsed seconds.

Parameters:
- ADDR_W, 20: SRAM word address width.
- MAX_ADDR, 20'hFFFFF: last writable address. Recording auto-stops when this address is written.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_key_rec  in  1  one-cycle pulse: start recording.
- i_key_play  in  1  one-cycle pulse: play / pause toggle.
- i_key_stop  in  1  one-cycle pulse: stop.
- i_sw  in  18  board switches. i_sw[17] = fast(1)/slow(0). i_sw[8:2] = speed select.
- i_adc_valid  in  1  one-cycle strobe: a new captured sample is on the SRAM data bus.
- i_dac_req  in  1  one-cycle strobe: the DAC consumes the current sample.
- o_state  out  3  0=IDLE, 1=HOLD, 2=REC, 3=PLAY, 4=PAUSE. Values 5-7 are never driven.
- o_sram_addr  out  ADDR_W  current SRAM address.
- o_sram_we  out  1  write enable, one-cycle pulse.
- o_end_addr  out  ADDR_W  sample count of the stored recording.
- o_speed  out  4  decoded speed factor, 1..8.
- o_fast  out  1  registered copy of i_sw[17].

Behaviour:
- Reset: o_state=IDLE, o_sram_addr=0, o_sram_we=0, o_end_addr=0, o_speed=1, o_fast=0, sub-step counter=0. Reset mid-record discards the recording: o_end_addr returns to 0.
- Speed decode:
  - Priority on i_sw[8:2]: highest set bit k gives speed = k (8..2); no bit set gives speed 1.
  - o_speed and o_fast are registered every cycle: 1-cycle latency from a switch change.
- Key priority when pulses coincide: stop > rec > play. Only the winning key acts.
- IDLE:
  - rec → REC with addr=0.
  - play and stop are ignored.
- REC:
  - On i_adc_valid: o_sram_we=1 in that same cycle at the current addr; addr+1 on the next edge.
  - Stop → HOLD with o_end_addr=addr (count written) and addr=0.
  - Writing at addr==MAX_ADDR → HOLD with o_end_addr=MAX_ADDR+1 truncated to ADDR_W bits. The full-memory case is encoded as o_end_addr=0 plus internal full flag=1. The full flag is cleared on the next rec.
  - Play is ignored.
- HOLD:
  - play → PLAY, addr=0, sub=0. If no samples are stored (o_end_addr=0 and full=0), play is ignored and the block stays in HOLD.
  - rec → REC, addr=0 (overwrite).
- PLAY, on each i_dac_req:
  - Fast: next = addr + o_speed.
  - Slow: if sub >= o_speed-1 then next = addr+1 and sub=0; otherwise sub+1 and addr held. The `>=` keeps behaviour safe when the speed shrinks mid-stretch.
  - If next >= stored length (ADDR_W+1-bit compare, so there is no wrap): → HOLD, addr=0.
  - Otherwise addr=next.
  - play → PAUSE (addr and sub frozen). stop → HOLD, addr=0. rec → REC, addr=0.
- PAUSE:
  - play → PLAY, resuming the same addr and sub.
  - stop → HOLD, addr=0. rec → REC, addr=0.
  - i_dac_req is ignored.
- A key pulse coinciding with i_adc_valid / i_dac_req: the key wins the transition. The strobe still completes in its own state:
  - REC + stop + adc_valid: the write happens and is counted in o_end_addr.
  - PLAY + play + dac_req: the step happens, then PAUSE.
- o_sram_we is 0 in every state except REC.

Decomposition:
- Package rec_pkg:
  - state_t enum (IDLE=3'd0, HOLD=3'd1, REC=3'd2, PLAY=3'd3, PAUSE=3'd4), shared with the display block.
  - ADDR_W default.
  - SPEED_MIN=1, SPEED_MAX=8.
- Sub-module speed_decode: combinational priority encoder, i_sw[8:2] → 4-bit speed.

Test Plan:
- Reset, then rec pulse, then 5 adc_valid strobes, then stop → 5 we pulses at addr 0..4; o_end_addr=5; o_state=1; o_sram_addr=0.
- From HOLD with end=5, fast, i_sw[3]=1 (speed 3): play, then 2 dac_req → addr 0→3, then → HOLD with addr=0 (6 ≥ 5).
- Slow, i_sw[2]=1 (speed 2), end=5: play, then 4 dac_req → addr sequence 0,1,1,2 (addr held on every other request).
- PLAY at addr=2: play pulse → PAUSE; 3 dac_req leave addr=2; play → PLAY and the next dac_req steps from 2.
- Same-cycle stop+rec+play in PLAY → HOLD, addr=0. Same-cycle stop+adc_valid in REC at addr=7 → we=1 and o_end_addr=8.
- MAX_ADDR overridden to 3: record with continuous adc_valid → 4 writes, then auto HOLD. Mid-REC i_rst → IDLE, o_end_addr=0, and play is then ignored.
